// File: rtl/mem_access_stage_if.sv
// AGEX-to-MEM latch inputs and MEM latch outputs of the MEM stage.
// MEM_PERF_CNT_EN adds the perf_loads/perf_stores/perf_faults counters.
interface mem_access_stage_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int IOPBITS   = 6
);
  logic                 agex_valid;
  logic [31:0]          agex_inst;
  logic [DBITS-1:0]     agex_pc;
  logic [IOPBITS-1:0]   agex_op;
  logic [DBITS-1:0]     agex_inst_count;
  logic [REGNOBITS-1:0] agex_wregno;
  logic [DBITS-1:0]     agex_result;
  logic                 agex_wr_reg;
  logic                 agex_mem_rd;
  logic                 agex_mem_wr;
  logic [1:0]           agex_mem_size;
  logic                 agex_mem_unsigned;
  logic [DBITS-1:0]     agex_store_data;

  logic                 mem_valid;
  logic [31:0]          mem_inst;
  logic [DBITS-1:0]     mem_pc;
  logic [IOPBITS-1:0]   mem_op;
  logic [DBITS-1:0]     mem_inst_count;
  logic [REGNOBITS-1:0] mem_wregno;
  logic [DBITS-1:0]     mem_result;
  logic                 mem_wr_reg;
  logic                 mem_fault;
  logic [REGNOBITS+DBITS:0] from_MEM_to_DE;
`ifdef MEM_PERF_CNT_EN
  logic [DBITS-1:0]     perf_loads;
  logic [DBITS-1:0]     perf_stores;
  logic [DBITS-1:0]     perf_faults;
`endif

  modport master (
`ifdef MEM_PERF_CNT_EN
    input  perf_loads, perf_stores, perf_faults,
`endif
    output agex_valid, agex_inst, agex_pc, agex_op,
    output agex_inst_count, agex_wregno, agex_result,
    output agex_wr_reg, agex_mem_rd, agex_mem_wr,
    output agex_mem_size, agex_mem_unsigned,
    output agex_store_data,
    input  mem_valid, mem_inst, mem_pc, mem_op,
    input  mem_inst_count, mem_wregno, mem_result,
    input  mem_wr_reg, mem_fault, from_MEM_to_DE
  );

  modport slave (
`ifdef MEM_PERF_CNT_EN
    output perf_loads, perf_stores, perf_faults,
`endif
    input  agex_valid, agex_inst, agex_pc, agex_op,
    input  agex_inst_count, agex_wregno, agex_result,
    input  agex_wr_reg, agex_mem_rd, agex_mem_wr,
    input  agex_mem_size, agex_mem_unsigned,
    input  agex_store_data,
    output mem_valid, mem_inst, mem_pc, mem_op,
    output mem_inst_count, mem_wregno, mem_result,
    output mem_wr_reg, mem_fault, from_MEM_to_DE
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data memory load/store and MEM latch.
// Optional MEM_PERF_CNT_EN adds saturating load/store/fault counters.
module mem_access_stage #(
  parameter int DBITS      = 32,
  parameter int DMEM_WORDS = 1024,
  parameter int REGNOBITS  = 5,
  parameter int IOPBITS    = 6
) (
  input  logic clk,
  input  logic reset,
  mem_access_stage_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [DBITS-1:0] dmem_q [DMEM_WORDS];

  logic [AW-1:0]    idx;
  logic [1:0]       off;
  logic             is_b, is_h, is_w;
  logic             misal, ld, st;
  logic [DBITS-1:0] rword, ldata, wdata;
  logic [7:0]       bsel;
  logic [15:0]      hsel;
  logic [3:0]       be;

  assign idx   = bus.agex_result[AW+1:2];
  assign off   = bus.agex_result[1:0];
  assign is_b  = bus.agex_mem_size == 2'd0;
  assign is_h  = bus.agex_mem_size == 2'd1;
  assign is_w  = bus.agex_mem_size[1];
  assign misal = (is_h & off[0]) | (is_w & (off != 2'd0));
  assign ld    = bus.agex_valid & bus.agex_mem_rd;
  assign st    = bus.agex_valid & bus.agex_mem_wr;
  assign rword = dmem_q[idx];
  assign bsel  = 8'(rword >> {off, 3'b000});
  assign hsel  = 16'(rword >> {off[1], 4'b0000});

  // Lane selection: load extraction/extension and store enables
  always_comb begin
    ldata = rword;
    wdata = bus.agex_store_data;
    be    = 4'b1111;
    unique case (1'b1)
      is_b: begin
        ldata = bus.agex_mem_unsigned
              ? {{(DBITS-8){1'b0}}, bsel}
              : {{(DBITS-8){bsel[7]}}, bsel};
        wdata = {4{bus.agex_store_data[7:0]}};
        be    = 4'b0001 << off;
      end
      is_h: begin
        ldata = bus.agex_mem_unsigned
              ? {{(DBITS-16){1'b0}}, hsel}
              : {{(DBITS-16){hsel[15]}}, hsel};
        wdata = {2{bus.agex_store_data[15:0]}};
        be    = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
  end

  logic                 valid_q;
  logic [31:0]          inst_q;
  logic [DBITS-1:0]     pc_q, cnt_q;
  logic [IOPBITS-1:0]   op_q;
  logic [REGNOBITS-1:0] wregno_q;
  logic [DBITS-1:0]     result_q, result_d;
  logic                 wr_reg_q, wr_reg_d;
  logic                 fault_q, fault_d;

  assign result_d = ld ? (misal ? '0 : ldata)
                       : bus.agex_result;
  assign wr_reg_d = bus.agex_valid & bus.agex_wr_reg
                  & (bus.agex_wregno != '0)
                  & ~(ld & misal);
  assign fault_d  = (ld | st) & misal;

  // Byte-enabled store; misaligned stores and reset cycles never write
  always_ff @(posedge clk) begin
    if (!reset && st && !misal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // MEM latch: captures every cycle, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      wregno_q <= '0;
      result_q <= '0;
      wr_reg_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      valid_q  <= bus.agex_valid;
      inst_q   <= bus.agex_inst;
      pc_q     <= bus.agex_pc;
      op_q     <= bus.agex_op;
      cnt_q    <= bus.agex_inst_count;
      wregno_q <= bus.agex_wregno;
      result_q <= result_d;
      wr_reg_q <= wr_reg_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.mem_valid      = valid_q;
  assign bus.mem_inst       = inst_q;
  assign bus.mem_pc         = pc_q;
  assign bus.mem_op         = op_q;
  assign bus.mem_inst_count = cnt_q;
  assign bus.mem_wregno     = wregno_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_wr_reg     = wr_reg_q;
  assign bus.mem_fault      = fault_q;
  assign bus.from_MEM_to_DE = {valid_q & wr_reg_q, wregno_q, result_q};

`ifdef MEM_PERF_CNT_EN
  logic [DBITS-1:0] pld_q, pst_q, pft_q;

  // Saturating event counters for valid accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      pld_q <= '0;
      pst_q <= '0;
      pft_q <= '0;
    end else begin
      if (ld && !misal && pld_q != '1) pld_q <= pld_q + 1'b1;
      if (st && !misal && pst_q != '1) pst_q <= pst_q + 1'b1;
      if (fault_d && pft_q != '1) pft_q <= pft_q + 1'b1;
    end
  end

  assign bus.perf_loads  = pld_q;
  assign bus.perf_stores = pst_q;
  assign bus.perf_faults = pft_q;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed steps plus random ops
// checked against a byte-array memory model.
module tb_mem_access_stage;
  localparam int DW = 1024;
  localparam int NB = 4 * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.DBITS(32), .REGNOBITS(5), .IOPBITS(6)) bus ();

  mem_access_stage #(
    .DBITS(32), .DMEM_WORDS(DW), .REGNOBITS(5), .IOPBITS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0] mb [NB];
  int m_ld = 0, m_st = 0, m_ft = 0;

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] mload(int a, logic [1:0] sz, bit uns);
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == 2'd0) begin
      b = mb[a];
      return uns ? {24'h0, b} : 32'($signed(b));
    end
    if (sz == 2'd1) begin
      h = {mb[a+1], mb[a]};
      return uns ? {16'h0, h} : 32'($signed(h));
    end
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  task automatic op(input bit v, input bit wrr, input bit rd,
                    input bit wr, input logic [1:0] sz, input bit uns,
                    input logic [4:0] rn, input logic [31:0] res,
                    input logic [31:0] sd, input string tag);
    int a;
    bit mis;
    logic [31:0] pc, ins, ic, e_res;
    logic [5:0] opc;
    bit e_wr, e_ft;
    pc  = $urandom;
    ins = $urandom;
    ic  = $urandom;
    opc = 6'($urandom);
    bus.agex_valid        = v;
    bus.agex_inst         = ins;
    bus.agex_pc           = pc;
    bus.agex_op           = opc;
    bus.agex_inst_count   = ic;
    bus.agex_wregno       = rn;
    bus.agex_result       = res;
    bus.agex_wr_reg       = wrr;
    bus.agex_mem_rd       = rd;
    bus.agex_mem_wr       = wr;
    bus.agex_mem_size     = sz;
    bus.agex_mem_unsigned = uns;
    bus.agex_store_data   = sd;
    a   = int'(res) & (NB - 1);
    mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
    e_res = (v && rd) ? (mis ? 32'h0 : mload(a, sz, uns)) : res;
    e_wr  = v && wrr && rn != 5'd0 && !(rd && mis);
    e_ft  = v && (rd || wr) && mis;
    @(posedge clk);
    #1;
    if (reset) begin
      m_ld = 0; m_st = 0; m_ft = 0;
      chk({tag, ".valid"}, 64'(bus.mem_valid), 0);
      chk({tag, ".wr"}, 64'(bus.mem_wr_reg), 0);
      chk({tag, ".fault"}, 64'(bus.mem_fault), 0);
      chk({tag, ".res"}, 64'(bus.mem_result), 0);
      chk({tag, ".rn"}, 64'(bus.mem_wregno), 0);
      chk({tag, ".pc"}, 64'(bus.mem_pc), 0);
      chk({tag, ".inst"}, 64'(bus.mem_inst), 0);
      chk({tag, ".op"}, 64'(bus.mem_op), 0);
      chk({tag, ".cnt"}, 64'(bus.mem_inst_count), 0);
      chk({tag, ".byp"}, 64'(bus.from_MEM_to_DE), 0);
    end else begin
      if (v && wr && !mis) begin
        mb[a] = sd[7:0];
        if (sz != 2'd0) mb[a+1] = sd[15:8];
        if (sz[1]) begin
          mb[a+2] = sd[23:16];
          mb[a+3] = sd[31:24];
        end
      end
      if (v && rd && !mis) m_ld++;
      if (v && wr && !mis) m_st++;
      if (e_ft) m_ft++;
      chk({tag, ".valid"}, 64'(bus.mem_valid), 64'(v));
      chk({tag, ".wr"}, 64'(bus.mem_wr_reg), 64'(e_wr));
      chk({tag, ".fault"}, 64'(bus.mem_fault), 64'(e_ft));
      if (v) begin
        chk({tag, ".res"}, 64'(bus.mem_result), 64'(e_res));
        chk({tag, ".rn"}, 64'(bus.mem_wregno), 64'(rn));
        chk({tag, ".pc"}, 64'(bus.mem_pc), 64'(pc));
        chk({tag, ".inst"}, 64'(bus.mem_inst), 64'(ins));
        chk({tag, ".op"}, 64'(bus.mem_op), 64'(opc));
        chk({tag, ".cnt"}, 64'(bus.mem_inst_count), 64'(ic));
        chk({tag, ".byp"}, 64'(bus.from_MEM_to_DE),
            64'({e_wr, rn, e_res}));
      end else begin
        chk({tag, ".byp0"}, 64'(bus.from_MEM_to_DE[37]), 0);
      end
    end
`ifdef MEM_PERF_CNT_EN
    chk({tag, ".pld"}, 64'(bus.perf_loads), 64'(m_ld));
    chk({tag, ".pst"}, 64'(bus.perf_stores), 64'(m_st));
    chk({tag, ".pft"}, 64'(bus.perf_faults), 64'(m_ft));
`endif
  endtask

  task automatic bub(string tag);
    op(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0, tag);
  endtask

  task automatic sw(logic [31:0] a, logic [31:0] d, string tag);
    op(1, 0, 0, 1, 2'd2, 0, 5'd0, a, d, tag);
  endtask

  initial begin
    bit v, wrr, rd, wr, uns;
    logic [1:0]  sz;
    logic [4:0]  rn;
    logic [31:0] ad;

    reset = 1'b1;
    bub("rst0");
    bub("rst1");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) bub("bubble");

    op(1, 1, 0, 0, 2'd0, 0, 5'd5, 32'h1234, 32'h0, "alu");
    chk("alu.lit", 64'(bus.mem_result), 64'h1234);
    chk("alu.wr", 64'(bus.mem_wr_reg), 1);
    op(1, 1, 0, 0, 2'd0, 0, 5'd0, 32'h77, 32'h0, "alu.x0");

    sw(32'h100, 32'hDEADBEEF, "sw100");
    op(1, 1, 1, 0, 2'd0, 0, 5'd3, 32'h103, 0, "lb");
    chk("lb.lit", 64'(bus.mem_result), 64'hFFFFFFDE);
    op(1, 1, 1, 0, 2'd0, 1, 5'd3, 32'h103, 0, "lbu");
    chk("lbu.lit", 64'(bus.mem_result), 64'h000000DE);
    op(1, 1, 1, 0, 2'd1, 0, 5'd3, 32'h102, 0, "lh");
    chk("lh.lit", 64'(bus.mem_result), 64'hFFFFDEAD);

    op(1, 0, 0, 1, 2'd0, 0, 5'd0, 32'h101, 32'hA5A5A555, "sb");
    op(1, 1, 1, 0, 2'd2, 0, 5'd4, 32'h100, 0, "lw");
    chk("lw.lit", 64'(bus.mem_result), 64'hDEAD55EF);
    op(1, 1, 1, 0, 2'd2, 0, 5'd4, 32'h100 + NB, 0, "lw.wrap");
    chk("wrap.lit", 64'(bus.mem_result), 64'hDEAD55EF);

    sw(32'h102, 32'h01234567, "sw.mis");
    chk("swmis.flt", 64'(bus.mem_fault), 1);
    op(1, 1, 1, 0, 2'd2, 0, 5'd4, 32'h100, 0, "lw.after");
    chk("unchg.lit", 64'(bus.mem_result), 64'hDEAD55EF);
    chk("flt.once", 64'(bus.mem_fault), 0);
    op(1, 1, 1, 0, 2'd2, 0, 5'd7, 32'h101, 0, "lw.mis");
    chk("lwmis.res", 64'(bus.mem_result), 0);
    chk("lwmis.wr", 64'(bus.mem_wr_reg), 0);
    chk("lwmis.flt", 64'(bus.mem_fault), 1);

    sw(32'h200, 32'hCAFEF00D, "sw200");
    op(1, 1, 0, 1, 2'd2, 0, 5'd9, 32'h200, 32'h0, "st.fwd");
    op(1, 1, 1, 0, 2'd2, 0, 5'd9, 32'h200, 0, "ld.fwd");
    chk("fwd.lit", 64'(bus.mem_result), 0);
    sw(32'h200, 32'hCAFEF00D, "sw200b");
    op(0, 0, 0, 1, 2'd2, 0, 5'd0, 32'h200, 32'h0, "st.bub");
    reset = 1'b1;
    sw(32'h200, 32'h11111111, "sw.rst");
    reset = 1'b0;
    op(1, 1, 1, 0, 2'd2, 0, 5'd6, 32'h200, 0, "lw200");
    chk("old.lit", 64'(bus.mem_result), 64'hCAFEF00D);
    sw(32'h204, 32'h0, "perf.sw");
    op(1, 1, 1, 0, 2'd1, 0, 5'd6, 32'h205, 0, "perf.lh");
`ifdef MEM_PERF_CNT_EN
    chk("perf.ld", 64'(bus.perf_loads), 1);
    chk("perf.st", 64'(bus.perf_stores), 1);
    chk("perf.ft", 64'(bus.perf_faults), 1);
`endif

    for (int i = 0; i < 16; i++)
      sw(32'(4 * i), $urandom, "init");
    for (int i = 0; i < 200; i++) begin
      v   = ($urandom % 8) != 0;
      rd  = 0;
      wr  = 0;
      case ($urandom % 3)
        0: rd = 1;
        1: wr = 1;
        default: ;
      endcase
      wrr = rd ? 1'b1 : (wr ? 1'b0 : 1'($urandom));
      sz  = 2'($urandom);
      uns = 1'($urandom);
      rn  = 5'($urandom);
      ad  = ($urandom % 64) + NB * ($urandom % 8);
      if (!rd && !wr) ad = $urandom;
      op(v, wrr, rd, wr, sz, uns, rn, ad, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
